// File: rtl/jtframe_vtiming_pkg.sv
// jtframe_vtiming_pkg
// Shared constants and helpers for the raster timing generator.
// The DEF_* constants are the default timing. Cores change the timing by
// overriding the jtframe_vtiming parameters, not by editing these values.
// Helpers:
//   wrap_sub  - (a - b) mod total, used to place a window start before a
//               reference point on a wrapping counter
//   win_step  - one update of a set/clear window flag
package jtframe_vtiming_pkg;

  localparam int DEF_HW       = 9;
  localparam int DEF_VW       = 9;
  localparam int DEF_HTOTAL   = 384;
  localparam int DEF_HB_START = 256;
  localparam int DEF_HB_END   = 0;
  localparam int DEF_HS_START = 288;
  localparam int DEF_HS_END   = 320;
  localparam int DEF_VTOTAL   = 264;
  localparam int DEF_VB_START = 240;
  localparam int DEF_VB_END   = 0;
  localparam int DEF_VS_START = 248;
  localparam int DEF_VS_END   = 251;
  localparam int DEF_FLIP_LSB = 3;
  localparam int DEF_DMA_LEAD = 8;

  function automatic int wrap_sub(input int a, input int b, input int total);
    return (((a - b) % total) + total) % total;
  endfunction

  // The end match takes priority over the start match, so a window with
  // START == END is never active.
  function automatic logic win_step(input logic cur, input logic at_start,
                                    input logic at_end);
    if (at_end)   return 1'b0;
    if (at_start) return 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/jtframe_vtiming_win.sv
// jtframe_vtiming_win
// Generic set/clear window register on a wrapping counter.
// The window sets on the update in which the counter becomes start_i and
// clears on the update in which it becomes end_i. start_i > end_i gives a
// window that spans the wrap.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cen_i       update qualifier (the counter takes its new value)
//   cnt_i       counter value being taken on this update
//   start_i     set point
//   end_i       clear point
//   win_o       registered window flag
//   win_d_o     next-state window flag, for registers aligned with win_o
module jtframe_vtiming_win
  import jtframe_vtiming_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen_i,
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] end_i,
  output logic         win_o,
  output logic         win_d_o
);

  logic win_q;
  logic win_d;

  always_comb begin
    win_d = win_q;
    if (cen_i) win_d = win_step(win_q, cnt_i == start_i, cnt_i == end_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= 1'b0;
    else        win_q <= win_d;
  end

  assign win_o   = win_q;
  assign win_d_o = win_d;

endmodule

// File: rtl/jtframe_vtiming.sv
// jtframe_vtiming
// Parametrised raster timing generator: free-running H/V counters,
// programmable blanking and sync windows, frame-latched flip, composite
// sync, DMA window and line/frame strobes. All outputs are registered and
// advance only on pxl_cen.
// Optional feature: define JTFRAME_VTIMING_INTERLACE_EN for interlaced
// fields (odd fields one line longer, odd-field VS edges at mid-line).
// Without it, field is constant 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pxl_cen      pixel clock enable
//   flip         screen flip request, latched when VB rises
//   Hraw, Vraw   unflipped counters
//   H, V         flipped counters (H keeps bits below FLIP_LSB)
//   HB, VB       blanking
//   HS, VS       sync, active-high
//   csync_n      ~(HS ^ VS)
//   dma_win_n    low from HB_START-DMA_LEAD to HB_END on VB lines
//   line_stb     one-clk pulse when Hraw wraps to 0
//   frame_stb    one-clk pulse when VB rises
//   field        interlace field
module jtframe_vtiming
  import jtframe_vtiming_pkg::*;
#(
  parameter int HW       = DEF_HW,
  parameter int VW       = DEF_VW,
  parameter int HTOTAL   = DEF_HTOTAL,
  parameter int HB_START = DEF_HB_START,
  parameter int HB_END   = DEF_HB_END,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int VTOTAL   = DEF_VTOTAL,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END   = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END,
  parameter int FLIP_LSB = DEF_FLIP_LSB,
  parameter int DMA_LEAD = DEF_DMA_LEAD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          flip,
  output logic [HW-1:0] Hraw,
  output logic [VW-1:0] Vraw,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic          HB,
  output logic          VB,
  output logic          HS,
  output logic          VS,
  output logic          csync_n,
  output logic          dma_win_n,
  output logic          line_stb,
  output logic          frame_stb,
  output logic          field
);

  if (HTOTAL > (1 << HW)) begin : g_htotal_chk
    $error("jtframe_vtiming: HTOTAL=%0d does not fit in HW=%0d bits", HTOTAL, HW);
  end
  if (VTOTAL + 1 > (1 << VW)) begin : g_vtotal_chk
    $error("jtframe_vtiming: VTOTAL+1=%0d does not fit in VW=%0d bits", VTOTAL + 1, VW);
  end

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] HB_S   = HW'(HB_START);
  localparam logic [HW-1:0] HB_E   = HW'(HB_END);
  localparam logic [HW-1:0] HS_S   = HW'(HS_START);
  localparam logic [HW-1:0] HS_E   = HW'(HS_END);
  localparam logic [VW-1:0] VB_S   = VW'(VB_START);
  localparam logic [VW-1:0] VB_E   = VW'(VB_END);
  localparam logic [VW-1:0] VS_S   = VW'(VS_START);
  localparam logic [VW-1:0] VS_E   = VW'(VS_END);
  localparam logic [HW-1:0] DMA_S  = HW'(wrap_sub(HB_START, DMA_LEAD, HTOTAL));
  localparam logic [HW-1:0] H_MASK = ~HW'((1 << FLIP_LSB) - 1);

  logic [HW-1:0] h_q, h_d, hflip_q;
  logic [VW-1:0] v_q, v_d, vflip_q, v_last;
  logic          h_wrap, v_cen, vs_cen, frame_rise;
  logic          flip_l_q, flip_l_d;
  logic          csync_n_q, dma_win_n_q, line_stb_q, frame_stb_q;
  logic          hb_q, hs_q, hs_d, vb_q, vb_d, vs_q, vs_d, dma_d;
  logic          hb_d_unused, dma_q_unused;

  assign h_wrap = (h_q == H_LAST);
  // Vertical windows only move when the line changes.
  assign v_cen  = pxl_cen & h_wrap;

`ifdef JTFRAME_VTIMING_INTERLACE_EN
  localparam logic [VW-1:0] V_LAST_ODD = VW'(VTOTAL);
  localparam logic [HW-1:0] H_HALF     = HW'(HTOTAL / 2);
  logic field_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          field_q <= 1'b0;
    else if (frame_rise) field_q <= ~field_q;
  end

  // Odd fields get one extra line and put the VS edges at mid-line.
  assign v_last = field_q ? V_LAST_ODD : V_LAST;
  assign vs_cen = pxl_cen & (field_q ? (h_d == H_HALF) : h_wrap);
  assign field  = field_q;
`else
  assign v_last = V_LAST;
  assign vs_cen = v_cen;
  assign field  = 1'b0;
`endif

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pxl_cen) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_d = (v_q == v_last) ? '0 : v_q + 1'b1;
    end
  end

  jtframe_vtiming_win #(.W(HW)) u_hb (
    .clk(clk), .rst_n(rst_n), .cen_i(pxl_cen), .cnt_i(h_d),
    .start_i(HB_S), .end_i(HB_E), .win_o(hb_q), .win_d_o(hb_d_unused));

  jtframe_vtiming_win #(.W(HW)) u_hs (
    .clk(clk), .rst_n(rst_n), .cen_i(pxl_cen), .cnt_i(h_d),
    .start_i(HS_S), .end_i(HS_E), .win_o(hs_q), .win_d_o(hs_d));

  // Only the next-state value is used; dma_win_n is registered below
  // together with the VB gate.
  jtframe_vtiming_win #(.W(HW)) u_dma (
    .clk(clk), .rst_n(rst_n), .cen_i(pxl_cen), .cnt_i(h_d),
    .start_i(DMA_S), .end_i(HB_E), .win_o(dma_q_unused), .win_d_o(dma_d));

  jtframe_vtiming_win #(.W(VW)) u_vb (
    .clk(clk), .rst_n(rst_n), .cen_i(v_cen), .cnt_i(v_d),
    .start_i(VB_S), .end_i(VB_E), .win_o(vb_q), .win_d_o(vb_d));

  jtframe_vtiming_win #(.W(VW)) u_vs (
    .clk(clk), .rst_n(rst_n), .cen_i(vs_cen), .cnt_i(v_d),
    .start_i(VS_S), .end_i(VS_E), .win_o(vs_q), .win_d_o(vs_d));

  assign frame_rise = pxl_cen & vb_d & ~vb_q;
  // The flip request is taken once per frame so the picture never tears.
  assign flip_l_d   = frame_rise ? flip : flip_l_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      hflip_q     <= '0;
      vflip_q     <= '0;
      flip_l_q    <= 1'b0;
      csync_n_q   <= 1'b1;
      dma_win_n_q <= 1'b1;
      line_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      flip_l_q    <= flip_l_d;
      hflip_q     <= h_d ^ (H_MASK & {HW{flip_l_d}});
      vflip_q     <= v_d ^ {VW{flip_l_d}};
      csync_n_q   <= ~(hs_d ^ vs_d);
      dma_win_n_q <= ~(dma_d & vb_d);
      line_stb_q  <= pxl_cen & h_wrap;
      frame_stb_q <= frame_rise;
    end
  end

  assign Hraw      = h_q;
  assign Vraw      = v_q;
  assign H         = hflip_q;
  assign V         = vflip_q;
  assign HB        = hb_q;
  assign HS        = hs_q;
  assign VB        = vb_q;
  assign VS        = vs_q;
  assign csync_n   = csync_n_q;
  assign dma_win_n = dma_win_n_q;
  assign line_stb  = line_stb_q;
  assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_jtframe_vtiming.sv
// tb_jtframe_vtiming
// Three instances share clock, reset, pxl_cen and flip:
//   dut_d  default timing (line-level behaviour of the 384x264 raster)
//   dut_w  wrapped HB window 370..10 with VB from line 1 (DMA window test)
//   dut_s  small 24x20 raster so whole frames, flip and reset fit in a short run
// Expected values come from plain counters kept by the bench and the
// window positions written out by hand for each instance.
module tb_jtframe_vtiming;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pxl_cen = 1'b0;
  logic flip = 1'b0;

  always #5 clk = ~clk;

  logic [8:0] d_hraw, d_vraw, d_h, d_v;
  logic d_hb, d_vb, d_hs, d_vs, d_csync_n, d_dma_n, d_lstb, d_fstb, d_field;
  logic [8:0] w_hraw, w_vraw, w_h, w_v;
  logic w_hb, w_vb, w_hs, w_vs, w_csync_n, w_dma_n, w_lstb, w_fstb, w_field;
  logic [4:0] s_hraw, s_vraw, s_h, s_v;
  logic s_hb, s_vb, s_hs, s_vs, s_csync_n, s_dma_n, s_lstb, s_fstb, s_field;

  jtframe_vtiming dut_d (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
    .Hraw(d_hraw), .Vraw(d_vraw), .H(d_h), .V(d_v), .HB(d_hb), .VB(d_vb),
    .HS(d_hs), .VS(d_vs), .csync_n(d_csync_n), .dma_win_n(d_dma_n),
    .line_stb(d_lstb), .frame_stb(d_fstb), .field(d_field));

  jtframe_vtiming #(.HB_START(370), .HB_END(10), .VB_START(1), .VB_END(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
    .Hraw(w_hraw), .Vraw(w_vraw), .H(w_h), .V(w_v), .HB(w_hb), .VB(w_vb),
    .HS(w_hs), .VS(w_vs), .csync_n(w_csync_n), .dma_win_n(w_dma_n),
    .line_stb(w_lstb), .frame_stb(w_fstb), .field(w_field));

  jtframe_vtiming #(.HW(5), .VW(5), .HTOTAL(24), .HB_START(16), .HB_END(0),
                    .HS_START(18), .HS_END(20), .VTOTAL(20), .VB_START(15),
                    .VB_END(0), .VS_START(17), .VS_END(19), .FLIP_LSB(3),
                    .DMA_LEAD(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
    .Hraw(s_hraw), .Vraw(s_vraw), .H(s_h), .V(s_v), .HB(s_hb), .VB(s_vb),
    .HS(s_hs), .VS(s_vs), .csync_n(s_csync_n), .dma_win_n(s_dma_n),
    .line_stb(s_lstb), .frame_stb(s_fstb), .field(s_field));

  int n_cmp = 0;
  int n_err = 0;

  // Bench counters: hx/vx for the 384-pixel instances, sh/sv for dut_s.
  int hx = 0, vx = 0, sh = 0, sv = 0;
  int lstb_m = 0, fstb_m = 0, s_lstb_m = 0, s_fstb_m = 0;
  int flip_m = 0, field_m = 0, frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hx = 0; vx = 0; sh = 0; sv = 0;
    lstb_m = 0; fstb_m = 0; s_lstb_m = 0; s_fstb_m = 0;
    flip_m = 0; field_m = 0;
  endtask

  task automatic model_update();
    int sv_last;
    hx = (hx == 383) ? 0 : hx + 1;
    if (hx == 0) begin
      vx = (vx == 263) ? 0 : vx + 1;
      lstb_m = 1;
      if (vx == 240) fstb_m = 1;
    end
    sv_last = 19;
`ifdef JTFRAME_VTIMING_INTERLACE_EN
    sv_last = 19 + field_m;
`endif
    sh = (sh == 23) ? 0 : sh + 1;
    if (sh == 0) begin
      sv = (sv == sv_last) ? 0 : sv + 1;
      s_lstb_m = 1;
      if (sv == 15) begin
        s_fstb_m = 1;
        flip_m = int'(flip);
`ifdef JTFRAME_VTIMING_INTERLACE_EN
        field_m = 1 - field_m;
`endif
        frames++;
        $display("frame %0d: field=%0d flip_l=%0d at %0t", frames, field_m, flip_m, $time);
      end
    end
  endtask

  task automatic check_all();
    int hs_e, vs_e, vb_e;
    // default instance
    hs_e = int'(hx >= 288 && hx < 320);
    vs_e = int'(vx >= 248 && vx < 251);
    vb_e = int'(vx >= 240);
    check("d_hraw", 32'(d_hraw), 32'(hx));
    check("d_vraw", 32'(d_vraw), 32'(vx));
    check("d_h", 32'(d_h), 32'(hx));
    check("d_v", 32'(d_v), 32'(vx));
    check("d_hb", 32'(d_hb), 32'(hx >= 256));
    check("d_hs", 32'(d_hs), 32'(hs_e));
    check("d_vb", 32'(d_vb), 32'(vb_e));
    check("d_vs", 32'(d_vs), 32'(vs_e));
    check("d_csync_n", 32'(d_csync_n), 32'((hs_e ^ vs_e) == 0));
    check("d_dma_n", 32'(d_dma_n), 32'(!(vb_e == 1 && hx >= 248)));
    check("d_line_stb", 32'(d_lstb), 32'(lstb_m));
    check("d_frame_stb", 32'(d_fstb), 32'(fstb_m));
    check("d_field", 32'(d_field), 32'(0));
    // wrapped-window instance, from its first VB line on
    check("w_hraw", 32'(w_hraw), 32'(hx));
    if (vx >= 1) begin
      check("w_hb", 32'(w_hb), 32'(hx >= 370 || hx < 10));
      check("w_dma_n", 32'(w_dma_n), 32'(!(hx >= 362 || hx < 10)));
    end
    // small instance
    hs_e = int'(sh >= 18 && sh < 20);
    vs_e = int'(sv >= 17 && sv < 19);
`ifdef JTFRAME_VTIMING_INTERLACE_EN
    if (field_m == 1) vs_e = int'((sv == 17 && sh >= 12) || sv == 18 || (sv == 19 && sh < 12));
`endif
    vb_e = int'(sv >= 15);
    check("s_hraw", 32'(s_hraw), 32'(sh));
    check("s_vraw", 32'(s_vraw), 32'(sv));
    check("s_h", 32'(s_h), 32'(flip_m != 0 ? (sh ^ 24) : sh));
    check("s_v", 32'(s_v), 32'(flip_m != 0 ? (sv ^ 31) : sv));
    check("s_hb", 32'(s_hb), 32'(sh >= 16));
    check("s_hs", 32'(s_hs), 32'(hs_e));
    check("s_vb", 32'(s_vb), 32'(vb_e));
    check("s_vs", 32'(s_vs), 32'(vs_e));
    check("s_csync_n", 32'(s_csync_n), 32'((hs_e ^ vs_e) == 0));
    check("s_dma_n", 32'(s_dma_n), 32'(!(vb_e == 1 && sh >= 12)));
    check("s_line_stb", 32'(s_lstb), 32'(s_lstb_m));
    check("s_frame_stb", 32'(s_fstb), 32'(s_fstb_m));
    check("s_field", 32'(s_field), 32'(field_m));
  endtask

  // One clock: drive pxl_cen, step past the edge, advance the bench
  // counters if the DUT should have updated, then compare everything.
  task automatic tick(input bit cen);
    pxl_cen = cen;
    @(posedge clk);
    #1;
    lstb_m = 0; fstb_m = 0; s_lstb_m = 0; s_fstb_m = 0;
    if (rst_n && cen) model_update();
    check_all();
  endtask

  initial begin
    int c;
    $display("reset: outputs held at reset values");
    for (int i = 0; i < 3; i++) tick(1'b0);
    rst_n = 1'b1;

    // Continuous pxl_cen: three default lines, over two small frames.
    // flip rises at small line 5 and falls before the second frame's VB.
    $display("run: pxl_cen every clock, flip toggling mid-frame");
    for (int i = 0; i < 1152; i++) begin
      if (i == 120) flip = 1'b1;
      if (i == 700) flip = 1'b0;
      tick(1'b1);
    end

    // Quarter-rate pxl_cen up to small line 5, pixel 10, then reset.
    $display("run: pxl_cen 1/4 up to small line 5 pixel 10");
    c = 0;
    while (!(sv == 5 && sh == 10) && c < 4000) begin
      tick((c % 4) == 0);
      c++;
    end
    if (c >= 4000) check("reach_line5", 32'(0), 32'(1));

    $display("reset: asynchronous assertion mid-frame");
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_s_hraw", 32'(s_hraw), 32'(0));
    check("rst_s_vraw", 32'(s_vraw), 32'(0));
    check("rst_s_csync_n", 32'(s_csync_n), 32'(1));
    check("rst_s_dma_n", 32'(s_dma_n), 32'(1));
    check("rst_s_line_stb", 32'(s_lstb), 32'(0));
    check("rst_d_hraw", 32'(d_hraw), 32'(0));
    check("rst_d_hb", 32'(d_hb), 32'(0));
    model_reset();
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;

    $display("run: restart after reset with pxl_cen 1/4");
    for (int i = 0; i < 600; i++) begin
      tick((i % 4) == 0);
      if (i == 0) check("restart_s_hraw", 32'(s_hraw), 32'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
